// File: rtl/rr_arb_lock_tree.sv
// ---------------------------------------------------------------------------
// rr_arb_lock_tree
//   Round-robin arbiter that merges NumIn requesters onto one output port.
//   Features:
//   - Fair pointer: the next scan starts at the last winner + 1, or at
//     pointer + 1 when FairArb=0.
//   - Decision lock: while the output is stalled, the selection is held.
//   - flush_i: synchronous clear of the pointer and the lock.
//   - Optional one-entry output pipeline register.
//
// Configuration macro: RR_ARB_LOCK_TREE_OUT_REG_EN
//   defined   : req_o/data_o/idx_o come from a full-throughput register
//               (1-cycle latency).
//   undefined : combinational path from req_i to req_o/data_o/idx_o.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   flush_i  synchronous clear of the pointer and the lock
//   req_i    per-input request             gnt_o   per-input grant (one-hot/zero)
//   data_i   per-input payload             data_o  selected payload
//   req_o    output request                gnt_i   output grant
//   idx_o    index of the selected input
// ---------------------------------------------------------------------------
module rr_arb_lock_tree #(
  parameter int unsigned NumIn     = 8,
  parameter int unsigned DataWidth = 32,
  parameter bit          FairArb   = 1'b1,
  parameter bit          LockIn    = 1'b1,
  parameter int unsigned IdxWidth  = (NumIn > 32'd1) ? $clog2(NumIn) : 32'd1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [NumIn-1:0]                req_i,
  output logic [NumIn-1:0]                gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0] data_i,
  output logic                            req_o,
  input  logic                            gnt_i,
  output logic [DataWidth-1:0]            data_o,
  output logic [IdxWidth-1:0]             idx_o
);

  localparam logic [IdxWidth:0]   NUM_IN_EXT = (IdxWidth + 1)'(NumIn);
  localparam logic [IdxWidth-1:0] LAST_IDX   = IdxWidth'(NumIn - 32'd1);

  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic                lock_q;
  logic [IdxWidth-1:0] scan_idx;
  logic [IdxWidth-1:0] sel;
  logic [IdxWidth-1:0] rr_base;
  logic [IdxWidth-1:0] rr_next;
  logic [IdxWidth:0]   cand;
  logic                found;
  logic                lock_hit;
  logic                arb_valid;
  logic                arb_ready;
  logic                hs;
  logic                stall;

  // Cyclic first-requester search starting at the pointer, modulo NumIn
  always_comb begin
    scan_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand     = {1'b0, rr_q} + (IdxWidth + 1)'(k);
      cand     = (cand >= NUM_IN_EXT) ? (cand - NUM_IN_EXT) : cand;
      scan_idx = (!found && req_i[cand[IdxWidth-1:0]]) ? cand[IdxWidth-1:0] : scan_idx;
      found    = found | req_i[cand[IdxWidth-1:0]];
    end
  end

  // A held lock only overrides the scan while its requester is still asking
  assign lock_hit  = lock_q & req_i[lock_idx_q];
  assign sel       = lock_hit ? lock_idx_q : scan_idx;
  assign arb_valid = |req_i;
  assign hs        = arb_valid & arb_ready;
  assign stall     = arb_valid & ~arb_ready;

  // Next pointer: winner+1 (fair) or pointer+1, wrapping at NumIn-1
  always_comb begin
    rr_base = FairArb ? sel : rr_q;
    rr_next = (rr_base == LAST_IDX) ? '0 : (rr_base + IdxWidth'(1'b1));
  end

  // Grant goes only to the selected input, and only when it really requests
  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = arb_ready & req_i[sel];
  end

  if (NumIn > 1) begin : g_ptr
    // Priority pointer and stall lock; flush has priority over a handshake
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        rr_q       <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        if (hs) begin
          rr_q <= rr_next;
        end else begin
          rr_q <= rr_q;
        end
        // Lock follows the stall: set on stall, cleared on handshake or idle
        lock_q     <= LockIn & stall;
        lock_idx_q <= sel;
      end
    end
  end else begin : g_single
    assign rr_q       = '0;
    assign lock_q     = 1'b0;
    assign lock_idx_q = '0;
  end

`ifdef RR_ARB_LOCK_TREE_OUT_REG_EN
  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic [IdxWidth-1:0]  idx_q;

  // Accept a new entry whenever the slot is empty or being drained
  assign arb_ready = ~valid_q | gnt_i;

  // One-entry output pipeline register; untouched by flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (arb_ready) begin
      valid_q <= arb_valid;
      if (arb_valid) begin
        data_q <= data_i[sel];
        idx_q  <= sel;
      end else begin
        data_q <= data_q;
        idx_q  <= idx_q;
      end
    end else begin
      valid_q <= valid_q;
      data_q  <= data_q;
      idx_q   <= idx_q;
    end
  end

  assign req_o  = valid_q;
  assign data_o = data_q;
  assign idx_o  = idx_q;
`else
  assign arb_ready = gnt_i;
  assign req_o     = arb_valid;
  assign data_o    = data_i[sel];
  assign idx_o     = sel;
`endif

`ifndef SYNTHESIS
  rr_arb_lock_tree_chk #(
    .NumIn    (NumIn),
    .IdxWidth (IdxWidth)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lock_q     (lock_q),
    .lock_idx_q (lock_idx_q),
    .req_i      (req_i),
    .gnt_o      (gnt_o)
  );
`endif

endmodule

// ---------------------------------------------------------------------------
// rr_arb_lock_tree_chk
//   Simulation-only protocol checker for rr_arb_lock_tree.
//   Ports: clock/reset, lock state, requests, and grants of the arbiter.
// ---------------------------------------------------------------------------
module rr_arb_lock_tree_chk #(
  parameter int unsigned NumIn    = 8,
  parameter int unsigned IdxWidth = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                lock_q,
  input logic [IdxWidth-1:0] lock_idx_q,
  input logic [NumIn-1:0]    req_i,
  input logic [NumIn-1:0]    gnt_o
);

  // A locked requester must hold its request; grants are never multi-hot
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(lock_q && !req_i[lock_idx_q]));
      assert ($onehot0(gnt_o));
    end
  end

endmodule
